// File: rtl/hazard_scoreboard_pkg.sv
// hazard_pkg: scoreboard entry type and forward-select encoding shared by the hazard controller.
package hazard_pkg;
  localparam int MAX_AW = 8;
  localparam logic [2:0] FWD_RF = 3'd0;
  typedef struct packed {
    logic v;
    logic [MAX_AW-1:0] dest;
    logic wb_en;
    logic mem_read;
    logic s;
  } sb_entry_t;
  function automatic logic [2:0] fwd_code(input int k);
    return 3'(k + 1);
  endfunction
endpackage

// File: rtl/hazard_scoreboard_prio_enc.sv
// hs_prio_enc: lowest-index priority encoder; the youngest in-flight producer wins.
module hs_prio_enc
  import hazard_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0] req_i,
  output logic         hit_o,
  output logic [2:0]   code_o
);
  assign hit_o = |req_i;
  always_comb begin
    code_o = FWD_RF;
    for (int i = N - 1; i >= 0; i--) code_o = req_i[i] ? fwd_code(i) : code_o;
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight writers EX..WB and derives ID stall, operand forwarding and branch flush.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW = 4,
  parameter int STAGES = 3,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_use_src1,
  input  logic              id_two_src,
  input  logic              id_use_flags,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_wb_en,
  input  logic              id_mem_read,
  input  logic              id_s,
  input  logic              br_taken,
  output logic              stall,
  output logic              flush,
  output logic [2:0]        fwd_sel_a,
  output logic [2:0]        fwd_sel_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  sb_entry_t sb_q [STAGES];
  sb_entry_t sb_d [STAGES];
  logic [STAGES-1:0] match1, match2;
  logic hit_a, hit_b, flag_hz, raw_hz;
  logic [2:0] code_a, code_b;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      match1[k] = sb_q[k].v & sb_q[k].wb_en & id_use_src1 & (sb_q[k].dest == MAX_AW'(id_src1));
      match2[k] = sb_q[k].v & sb_q[k].wb_en & id_two_src & (sb_q[k].dest == MAX_AW'(id_src2));
    end
  end
  hs_prio_enc #(.N(STAGES)) u_enc_a (.req_i(match1), .hit_o(hit_a), .code_o(code_a));
  hs_prio_enc #(.N(STAGES)) u_enc_b (.req_i(match2), .hit_o(hit_b), .code_o(code_b));
  // With forwarding only a load in EX cannot be bypassed in time.
  assign flag_hz   = sb_q[0].v & sb_q[0].s & id_use_flags & id_valid;
  assign raw_hz    = (FWD_EN != 0) ? sb_q[0].mem_read & (match1[0] | match2[0]) : hit_a | hit_b;
  assign flush     = br_taken;
  assign stall     = id_valid & ~flush & (raw_hz | flag_hz);
  assign fwd_sel_a = (FWD_EN != 0 && id_valid && hit_a) ? code_a : FWD_RF;
  assign fwd_sel_b = (FWD_EN != 0 && id_valid && hit_b) ? code_b : FWD_RF;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  always_comb begin
    sb_d[0] = (stall | flush) ? '0 : sb_entry_t'{v: id_valid, dest: MAX_AW'(id_dest),
                                                 wb_en: id_wb_en, mem_read: id_mem_read, s: id_s};
    for (int k = 1; k < STAGES; k++) sb_d[k] = sb_q[k-1];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < STAGES; k++) sb_q[k] <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      sb_q        <= sb_d;
      stall_cnt_q <= stall_cnt_q + CNT_W'(stall & ~&stall_cnt_q);
      flush_cnt_q <= flush_cnt_q + CNT_W'(flush & ~&flush_cnt_q);
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: table-driven and hand-sequenced checks of forwarding and interlock behaviour.
module tb_hazard_scoreboard;
  typedef struct {
    logic v, u1, two, fl, wb, mr, s, br;
    logic [3:0] s1, s2, d;
    logic es, ef;
    logic [2:0] ea, eb;
  } vec_t;
  logic clk = 1'b0, rst = 1'b0;
  logic id_valid, id_use_src1, id_two_src, id_use_flags, id_wb_en, id_mem_read, id_s, br_taken;
  logic [3:0] id_src1, id_src2, id_dest;
  logic stall1, flush1, stall0, flush0;
  logic [2:0] a1, b1, a0, b0;
  logic [3:0] sc1, fc1, sc0, fc0;
  int n_cmp = 0, n_err = 0;
  vec_t tbl [17];
  vec_t exp_q [$];
  always #5 clk = ~clk;
  hazard_scoreboard #(.REG_AW(4), .STAGES(3), .FWD_EN(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src1(id_use_src1), .id_two_src(id_two_src), .id_use_flags(id_use_flags),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .id_s(id_s),
    .br_taken(br_taken), .stall(stall1), .flush(flush1), .fwd_sel_a(a1), .fwd_sel_b(b1),
    .stall_cnt(sc1), .flush_cnt(fc1));
  hazard_scoreboard #(.REG_AW(4), .STAGES(3), .FWD_EN(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src1(id_use_src1), .id_two_src(id_two_src), .id_use_flags(id_use_flags),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .id_s(id_s),
    .br_taken(br_taken), .stall(stall0), .flush(flush0), .fwd_sel_a(a0), .fwd_sel_b(b0),
    .stall_cnt(sc0), .flush_cnt(fc0));
  function automatic vec_t mk(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                              input logic u1, input logic two, input logic fl, input logic [3:0] d,
                              input logic wb, input logic mr, input logic s, input logic br,
                              input logic es, input logic ef, input logic [2:0] ea, input logic [2:0] eb);
    vec_t r;
    r.v = v; r.s1 = s1; r.s2 = s2; r.u1 = u1; r.two = two; r.fl = fl; r.d = d;
    r.wb = wb; r.mr = mr; r.s = s; r.br = br; r.es = es; r.ef = ef; r.ea = ea; r.eb = eb;
    return r;
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic drive(input vec_t x);
    id_valid = x.v; id_src1 = x.s1; id_src2 = x.s2; id_use_src1 = x.u1; id_two_src = x.two;
    id_use_flags = x.fl; id_dest = x.d; id_wb_en = x.wb; id_mem_read = x.mr; id_s = x.s;
    br_taken = x.br;
  endtask
  // Drives at posedge+1, checks combinational outputs at posedge+3, returns at next posedge+1.
  task automatic cyc(input vec_t x, input bit fwd, input string tag);
    vec_t e;
    drive(x);
    exp_q.push_back(x);
    #2;
    e = exp_q.pop_front();
    chk({tag, ".stall"}, fwd ? stall1 : stall0, e.es);
    chk({tag, ".flush"}, fwd ? flush1 : flush0, e.ef);
    chk({tag, ".fwd_a"}, fwd ? a1 : a0, e.ea);
    chk({tag, ".fwd_b"}, fwd ? b1 : b0, e.eb);
    @(posedge clk);
    #1;
  endtask
  initial begin
    vec_t ldr, mov2, add2;
    bit seen;
    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    repeat (2) @(posedge clk);
    #1;
    chk("rst.stall", stall1, 0); chk("rst.flush", flush1, 0); chk("rst.fwd_a", a1, 0);
    chk("rst.fwd_b", b1, 0); chk("rst.stall_cnt", sc1, 0); chk("rst.flush_cnt", fc1, 0);
    rst = 1'b1;
    tbl[0]  = mk(1,  1, 0, 0, 0, 0,  3, 1, 1, 0, 0,  0, 0, 0, 0);
    tbl[1]  = mk(1,  3, 4, 1, 1, 0,  5, 1, 0, 0, 0,  1, 0, 1, 0);
    tbl[2]  = mk(1,  3, 4, 1, 1, 0,  5, 1, 0, 0, 0,  0, 0, 2, 0);
    tbl[3]  = mk(1,  0, 0, 0, 0, 0,  2, 1, 0, 0, 0,  0, 0, 0, 0);
    tbl[4]  = mk(1,  2, 2, 1, 1, 0,  1, 1, 0, 0, 0,  0, 0, 1, 1);
    tbl[5]  = mk(1,  5, 2, 1, 1, 0,  4, 1, 0, 0, 0,  0, 0, 3, 2);
    tbl[6]  = mk(1,  0, 0, 0, 0, 0,  6, 1, 0, 0, 0,  0, 0, 0, 0);
    tbl[7]  = mk(1,  0, 0, 0, 0, 0,  4, 1, 0, 0, 0,  0, 0, 0, 0);
    tbl[8]  = mk(1,  4, 6, 1, 1, 0,  0, 0, 0, 0, 0,  0, 0, 1, 2);
    tbl[9]  = mk(1,  4, 6, 1, 0, 0,  0, 0, 0, 0, 0,  0, 0, 2, 0);
    tbl[10] = mk(1,  0, 0, 0, 0, 0, 15, 1, 1, 0, 0,  0, 0, 0, 0);
    tbl[11] = mk(1, 15, 0, 1, 0, 0,  0, 0, 0, 0, 1,  0, 1, 1, 0);
    tbl[12] = mk(1, 15, 0, 1, 0, 0,  0, 1, 0, 1, 0,  0, 0, 2, 0);
    tbl[13] = mk(1,  0, 0, 1, 0, 1,  9, 1, 0, 0, 0,  1, 0, 1, 0);
    tbl[14] = mk(1,  0, 0, 1, 0, 1,  9, 1, 0, 0, 0,  0, 0, 2, 0);
    tbl[15] = mk(0,  9, 9, 1, 1, 1,  9, 1, 0, 0, 0,  0, 0, 0, 0);
    tbl[16] = mk(1,  9, 0, 1, 0, 0,  0, 0, 0, 0, 0,  0, 0, 2, 0);
    for (int i = 0; i < 17; i++) cyc(tbl[i], 1'b1, $sformatf("tbl%0d", i));
    chk("tbl.stall_cnt", sc1, 2);
    chk("tbl.flush_cnt", fc1, 1);
    rst = 1'b0;
    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("rst2.stall_cnt0", sc0, 0);
    mov2 = mk(1, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0);
    add2 = mk(1, 2, 2, 1, 1, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0);
    cyc(mov2, 1'b0, "nofwd.mov");
    for (int i = 0; i < 3; i++) cyc(add2, 1'b0, $sformatf("nofwd.add%0d", i));
    add2.es = 1'b0;
    cyc(add2, 1'b0, "nofwd.add3");
    chk("nofwd.stall_cnt0", sc0, 3);
    chk("nofwd.stall_cnt1", sc1, 0);
    ldr = mk(1, 3, 0, 1, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0);
    drive(ldr);
    repeat (40) @(posedge clk);
    #1;
    chk("sat.stall_cnt1", sc1, 15);
    chk("sat.stall_cnt0", sc0, 15);
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      #2;
      seen = stall1;
      if (!seen) begin
        @(posedge clk);
        #1;
      end
    end
    chk("midrst.stall_before", stall1, 1);
    rst = 1'b0;
    #1;
    chk("midrst.stall1", stall1, 0); chk("midrst.stall0", stall0, 0);
    chk("midrst.stall_cnt1", sc1, 0); chk("midrst.stall_cnt0", sc0, 0);
    chk("midrst.flush_cnt1", fc1, 0); chk("midrst.fwd_a1", a1, 0);
    @(posedge clk);
    #3;
    chk("rstheld.stall1", stall1, 0); chk("rstheld.fwd_a1", a1, 0);
    rst = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard and forwarding controller for the five-stage ARM pipeline.
- Replaces the fixed "no hazard, no forward" wiring that ties freeze inputs to constant 0.
- Keeps a shift-register scoreboard of in-flight instructions (EX..WB). Each cycle it decides whether ID must stall, which stage forwards each source operand, and whether IF/ID are flushed on a taken branch.
- Sits beside the ID/EX boundary; its stall drives the IF/ID register freeze and the PC enable.

Parameters:
- REG_AW, 4, register address width.
- STAGES, 3, in-flight depth tracked (entry 0 = EX, entry STAGES-1 = WB); legal range 2..6.
- FWD_EN, 1, 1 = forwarding mode (stall only on load-use); 0 = stall on any RAW match.
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_src1  in  REG_AW  Rn address
- id_src2  in  REG_AW  Rm/Rd-for-store address
- id_use_src1  in  1  instruction reads src1
- id_two_src  in  1  instruction reads src2
- id_use_flags  in  1  instruction is conditional (reads NZCV)
- id_dest  in  REG_AW  destination address
- id_wb_en  in  1  instruction writes the register file
- id_mem_read  in  1  instruction is a load
- id_s  in  1  instruction updates NZCV
- br_taken  in  1  taken branch resolved in EX this cycle
- stall  out  1  freeze PC and IF/ID; insert bubble into EX
- flush  out  1  kill IF/ID contents
- fwd_sel_a  out  3  source of operand A (0 = register file, k+1 = scoreboard entry k)
- fwd_sel_b  out  3  same for operand B
- stall_cnt  out  CNT_W  cycles with stall=1
- flush_cnt  out  CNT_W  cycles with flush=1

Behaviour:
- Scoreboard entry fields: {v, dest, wb_en, mem_read, s}.
- Every cycle entries shift: sb[k+1] <= sb[k]. The WB entry falls off. The downstream pipe never stalls.
- sb[0] load rule:
  - sb[0] <= ID fields with v=id_valid when stall=0 and flush=0.
  - Otherwise sb[0] <= bubble (v=0, all fields 0).
- Match rules:
  - match1[k] = sb[k].v & sb[k].wb_en & id_use_src1 & (sb[k].dest == id_src1).
  - match2[k] is the same with id_two_src and id_src2.
- Flag hazard: flag_hz = sb[0].v & sb[0].s & id_use_flags & id_valid.
- Stall, FWD_EN=1: stall = id_valid & ~flush & ((sb[0].mem_read & (match1[0] | match2[0])) | flag_hz).
- Stall, FWD_EN=0: stall = id_valid & ~flush & (any match1 | any match2 | flag_hz).
- Forward selects:
  - FWD_EN=1: fwd_sel_a = lowest k with match1[k], encoded k+1, else 0. fwd_sel_b is the same on match2.
  - FWD_EN=0: both selects are always 0.
  - The youngest (lowest k) match always wins.
- stall, flush and fwd_sel_* are combinational from current scoreboard state and the ID inputs (zero latency). Counters are registered.
- flush = br_taken. When br_taken and a stall condition coincide, flush wins: stall=0 and sb[0] gets a bubble.
- A stalled instruction re-evaluates every cycle. Load-use with FWD_EN=1 gives exactly 1 stall cycle; the next cycle forwards from entry 1 (MEM).
- id_valid=0: stall=0, fwd_sel_*=0.
- Register 15 and register 0 are matched like any other address; there is no special case.
- Counters increment by 1 on each cycle with the respective output high, and saturate at all-ones (no wrap).
- Reset (asynchronous, rst=0): all entries v=0 and fields 0, counters 0. stall, flush and fwd_sel_* are therefore 0 while br_taken=0. Reset mid-stall clears the hazard immediately.

Decomposition:
- Package hazard_pkg:
  - sb_entry_t struct.
  - FWD_RF = 3'd0 constant.
  - Function fwd_code(k) returning k+1.
- Sub-module hs_prio_enc: STAGES-wide lowest-index priority encoder, output {hit, code[2:0]}. Instantiated twice, for operands A and B.

Test Plan:
- Load-use: load to R3 issued, then ADD reading R3 with FWD_EN=1 -> stall=1 for exactly 1 cycle, next cycle fwd_sel_a=2 (MEM), stall_cnt=1.
- Back-to-back ALU: MOV R2 then ADD R1,R2,R2 -> stall=0, fwd_sel_a=1, fwd_sel_b=1. Repeat with FWD_EN=0 -> stall for 3 cycles (STAGES=3), then fwd_sel=0.
- Priority: R4 written by entries 0 and 2, ID reads R4 -> fwd_sel_a=1, not 3.
- Branch vs stall: load-use pending while br_taken=1 -> flush=1, stall=0, next sb[0].v=0, flush_cnt increments, stall_cnt unchanged.
- Flag hazard: CMP (s=1) in EX, conditional MOVEQ in ID -> stall=1 for 1 cycle, then 0.
- Reset/saturation: drive stall continuously with CNT_W=4 -> stall_cnt holds 15. Assert rst=0 mid-stall -> stall, counters and all scoreboard entries return to 0 asynchronously.
